// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM speed-ramp controller.
package pwm_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_HOLD, ST_REVERSE} state_e;
  localparam int PERIOD_DEF = 19999;
  localparam int DUTY_W     = 15;
endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler; tick pulses for one cycle every TICK_DIV clocks.
module ramp_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] presc_q, presc_d;

  always_comb begin
    presc_d = (presc_q == LAST) ? '0 : presc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign tick = (presc_q == LAST);
endmodule

// File: rtl/pwm_ramp_ctl.sv
// Ramps PWM duty toward commanded targets at STEP per tick, passing through
// zero before any direction change so the motor never sees a step.
module pwm_ramp_ctl
  import pwm_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int STEP     = 100,
  parameter int TICK_DIV = 50000,
  parameter int W        = DUTY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_duty,
  input  logic         cmd_dir,
  output logic [W-1:0] para_out,
  output logic         dir_out,
  output logic         busy,
  output logic         at_target
);
  localparam logic [W-1:0] MAX_DUTY = W'(PERIOD - 1);
  localparam logic [W-1:0] STEP_V   = W'(STEP);
  localparam logic [W-1:0] PERIOD_V = W'(PERIOD);

  state_e       state_q, state_d;
  logic [W-1:0] duty_q, duty_d, tgt_duty_q, tgt_duty_d, para_q, para_d;
  logic         tgt_dir_q, tgt_dir_d, dir_q, dir_d;
  logic         tick, acc;
  logic [W-1:0] cmd_clamp, eff, step_duty;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cmd_ready = (state_q != ST_REVERSE);
  assign acc       = cmd_valid && cmd_ready;
  assign busy      = (state_q == ST_RAMP) || (state_q == ST_REVERSE);
  assign at_target = (duty_q == tgt_duty_q) && (dir_q == tgt_dir_q);
  assign para_out  = para_q;
  assign dir_out   = dir_q;

  always_comb begin
    cmd_clamp  = (cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd_duty;
    eff        = (state_q == ST_REVERSE) ? '0 : tgt_duty_q;
    if (eff >= duty_q) step_duty = (eff - duty_q <= STEP_V) ? eff : duty_q + STEP_V;
    else               step_duty = (duty_q - eff <= STEP_V) ? eff : duty_q - STEP_V;

    state_d    = state_q;
    duty_d     = duty_q;
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    dir_d      = dir_q;

    // The tick step always works from the target held before this edge.
    if (tick) begin
      duty_d = step_duty;
      case (state_q)
        ST_RAMP: if (step_duty == tgt_duty_q)
                   state_d = (tgt_duty_q != '0) ? ST_HOLD : ST_IDLE;
        ST_REVERSE: if (step_duty == '0) begin
                      dir_d   = tgt_dir_q;
                      state_d = (tgt_duty_q != '0) ? ST_RAMP : ST_IDLE;
                    end
        default: ;
      endcase
    end

    // New commands are compared against the duty leaving this edge.
    if (acc) begin
      tgt_duty_d = cmd_clamp;
      tgt_dir_d  = cmd_dir;
      if (cmd_dir != dir_q && duty_d != '0) begin
        state_d = ST_REVERSE;
      end else begin
        dir_d = cmd_dir;
        if (cmd_clamp != duty_d) state_d = ST_RAMP;
        else if (duty_d == '0)   state_d = ST_IDLE;
        else                     state_d = ST_HOLD;
      end
    end

    para_d = (duty_d == '0) ? '0 : PERIOD_V - duty_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
      dir_q      <= 1'b0;
      para_q     <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      dir_q      <= dir_d;
      para_q     <= para_d;
    end
  end
endmodule
